// File: rtl/load_store_unit_if.sv
// Datapath request/response and word-memory pin bundle for the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed,
        input  req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed,
        output req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store initiator for a word-wide data memory.
// Sub-word stores are read-modify-write; loads are sign/zero extended.
module load_store_unit #(
    parameter int MEM_WORDS = 32
) (
    input logic clk,
    input logic rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [1:0]  SZ_B     = 2'b00;
    localparam logic [1:0]  SZ_H     = 2'b01;
    localparam logic [1:0]  SZ_W     = 2'b10;
    localparam logic [29:0] LP_WORDS = 30'(MEM_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_merged;

    logic        w_ready;
    logic        w_accept;
    logic        w_illegal;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;
    logic [31:0] w_word_addr;

    assign w_ready     = (r_state == S_IDLE) & ~rst;
    assign w_accept    = w_ready & bus.req_valid;
    assign w_word_addr = {r_addr[31:2], 2'b00};

    always_comb begin
        w_illegal = 1'b0;
        unique case (1'b1)
            bus.req_size == 2'b11:
                w_illegal = 1'b1;
            bus.req_size == SZ_H:
                w_illegal = bus.req_addr[0];
            bus.req_size == SZ_W:
                w_illegal = |bus.req_addr[1:0];
            default:
                w_illegal = 1'b0;
        endcase
        if (bus.req_addr[31:2] >= LP_WORDS)
            w_illegal = 1'b1;
    end

    // Lane select and extension for loads
    always_comb begin
        w_byte = bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        w_load = bus.mem_rdata;
        case (r_size)
            SZ_B:    w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            SZ_H:    w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = bus.mem_rdata;
        endcase
    end

    // Store lane merged over the current word; other bytes preserved
    always_comb begin
        w_merged = bus.mem_rdata;
        case (r_size)
            SZ_B: w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            SZ_H: begin
                if (r_addr[1])
                    w_merged[31:16] = r_wdata[15:0];
                else
                    w_merged[15:0] = r_wdata[15:0];
            end
            default: w_merged = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        bus.req_ready  = w_ready;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = 32'h0;
        bus.mem_wdata  = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    unique case (1'b1)
                        w_illegal:
                            w_next = S_RESP;
                        bus.req_we && bus.req_size == SZ_W:
                            w_next = S_WRITE;
                        default:
                            w_next = S_READ;
                    endcase
                end
            end
            S_READ: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = w_word_addr;
                w_next       = r_we ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = w_word_addr;
                bus.mem_wdata = (r_size == SZ_W) ? r_wdata : r_merged;
                w_next        = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = r_err;
                bus.resp_rdata = r_rdata;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_err    <= 1'b0;
            r_rdata  <= 32'h0;
            r_merged <= 32'h0;
        end else if (w_accept) begin
            r_we     <= bus.req_we;
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_err    <= w_illegal;
            r_rdata  <= 32'h0;
        end else if (r_state == S_READ) begin
            if (r_we)
                r_merged <= w_merged;
            else
                r_rdata <= w_load;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 32-word
// behavioural memory attached to the memory pins.
module tb_load_store_unit;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    load_store_unit_if bus();

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:31];
    logic        pl_en;
    logic [4:0]  pl_idx;
    logic [31:0] pl_data;

    assign bus.mem_rdata = mem[bus.mem_addr[6:2]];

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (bus.mem_write)
            mem[bus.mem_addr[6:2]] <= bus.mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          cyc;
    int          n_rd;
    int          n_wr;
    int          n_resp;
    int          n_both;
    int          rd_cyc;
    int          wr_cyc;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;

    initial begin
        cyc = 0; n_rd = 0; n_wr = 0; n_resp = 0; n_both = 0;
        rd_cyc = 0; wr_cyc = 0; last_waddr = 0; last_wdata = 0;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.mem_read) begin
            n_rd++;
            rd_cyc = cyc;
        end
        if (bus.mem_write) begin
            n_wr++;
            wr_cyc = cyc;
            last_waddr = bus.mem_addr;
            last_wdata = bus.mem_wdata;
        end
        if (bus.resp_valid) n_resp++;
        if (bus.mem_read && bus.mem_write) n_both++;
    end

    task automatic preload(input logic [4:0] idx, input logic [31:0] d);
        pl_en = 1'b1; pl_idx = idx; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic set_req(input logic we, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a,
                           input logic [31:0] wd);
        bus.req_we = we; bus.req_size = sz; bus.req_signed = sg;
        bus.req_addr = a; bus.req_wdata = wd;
    endtask

    // Issues one request from IDLE; lat = -1 if no response in budget
    task automatic do_req(input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd, output logic er);
        lat = -1; rd = 32'hx; er = 1'bx;
        set_req(we, sz, sg, a, wd);
        bus.req_valid = 1'b1;
        for (int k = 0; k < 10 && !bus.req_ready; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.resp_valid) begin
                lat = k; rd = bus.resp_rdata; er = bus.resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0", bus.req_ready);
        end
        n_chk++;
        if ({bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000",
                     {bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write});
        end
        n_chk++;
        if ({bus.resp_rdata, bus.mem_addr, bus.mem_wdata} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h want 0",
                     bus.resp_rdata, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_ready: got %b want 1", bus.req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_word;
        int lat; logic [31:0] rd; logic er; int w0;
        w0 = n_wr;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
        n_chk++;
        if (lat !== 2) begin
            n_fail++; $display("FAIL sw_latency: got %0d want 2", lat);
        end
        n_chk++;
        if (n_wr - w0 !== 1 || last_waddr !== 32'h10) begin
            n_fail++;
            $display("FAIL sw_pulse: got %0d writes at %h want 1 at 00000010",
                     n_wr - w0, last_waddr);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
        n_chk++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL lw: got lat %0d data %h err %b want 2 deadbeef 0",
                     lat, rd, er);
        end
    endtask

    task automatic test_byte;
        int lat; logic [31:0] rd; logic er;
        preload(5'd4, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h80, lat, rd, er);
        n_chk++;
        if (lat !== 3 || er !== 1'b0) begin
            n_fail++; $display("FAIL sb_latency: got %0d err %b want 3 0", lat, er);
        end
        n_chk++;
        if (last_wdata !== 32'h80223344 || wr_cyc !== rd_cyc + 1) begin
            n_fail++;
            $display("FAIL sb_rmw: got wdata %h rd@%0d wr@%0d want 80223344 wr=rd+1",
                     last_wdata, rd_cyc, wr_cyc);
        end
        n_chk++;
        if (mem[4] !== 32'h80223344) begin
            n_fail++; $display("FAIL sb_mem: got %h want 80223344", mem[4]);
        end
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, er);
        n_chk++;
        if (lat !== 2 || rd !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL lb: got lat %0d data %h want 2 ffffff80", lat, rd);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er);
        n_chk++;
        if (rd !== 32'h00000080) begin
            n_fail++; $display("FAIL lbu: got %h want 00000080", rd);
        end
    endtask

    task automatic test_half;
        int lat; logic [31:0] rd; logic er;
        preload(5'd4, 32'h00001234);
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD, lat, rd, er);
        n_chk++;
        if (lat !== 3 || mem[4] !== 32'hABCD1234) begin
            n_fail++;
            $display("FAIL sh: got lat %0d mem %h want 3 abcd1234", lat, mem[4]);
        end
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, er);
        n_chk++;
        if (rd !== 32'hFFFFABCD) begin
            n_fail++; $display("FAIL lh: got %h want ffffabcd", rd);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, er);
        n_chk++;
        if (rd !== 32'h0000ABCD) begin
            n_fail++; $display("FAIL lhu_hi: got %h want 0000abcd", rd);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, rd, er);
        n_chk++;
        if (rd !== 32'h00001234) begin
            n_fail++; $display("FAIL lhu_lo: got %h want 00001234", rd);
        end
    endtask

    task automatic test_errors;
        int lat; logic [31:0] rd; logic er; int r0; int w0;
        logic        e_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  e_sz   [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] e_addr [4] = '{32'h06, 32'h03, 32'h00, 32'h80};
        preload(5'd0, 32'hA5A5A5A5);
        preload(5'd1, 32'h5A5A5A5A);
        r0 = n_rd; w0 = n_wr;
        for (int i = 0; i < 4; i++) begin
            do_req(e_we[i], e_sz[i], 1'b0, e_addr[i], 32'hFFFF, lat, rd, er);
            n_chk++;
            if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
                n_fail++;
                $display("FAIL err_%0d: got lat %0d err %b data %h want 1 1 0",
                         i, lat, er, rd);
            end
        end
        n_chk++;
        if (n_rd !== r0 || n_wr !== w0) begin
            n_fail++;
            $display("FAIL err_access: got %0d reads %0d writes want 0 0",
                     n_rd - r0, n_wr - w0);
        end
        n_chk++;
        if (mem[0] !== 32'hA5A5A5A5 || mem[1] !== 32'h5A5A5A5A) begin
            n_fail++;
            $display("FAIL err_mem: got %h %h want a5a5a5a5 5a5a5a5a", mem[0], mem[1]);
        end
    endtask

    task automatic test_reset_rmw;
        int w0; int p0;
        preload(5'd8, 32'h11111111);
        w0 = n_wr; p0 = n_resp;
        set_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h77);
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_chk++;
        if (bus.mem_read !== 1'b1) begin
            n_fail++; $display("FAIL rmw_read: got %b want 1", bus.mem_read);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if (bus.mem_write !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_in_reset: got write %b ready %b want 0 0",
                     bus.mem_write, bus.req_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rmw_ready: got %b want 1", bus.req_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (n_wr !== w0 || n_resp !== p0 || mem[8] !== 32'h11111111) begin
            n_fail++;
            $display("FAIL rmw_abort: got %0d writes %0d resps mem %h want 0 0 11111111",
                     n_wr - w0, n_resp - p0, mem[8]);
        end
    endtask

    task automatic test_back_to_back;
        logic        b_we [10] = '{1, 0, 1, 0, 1, 0, 0, 0, 1, 0};
        logic [1:0]  b_sz [10] = '{2, 2, 0, 2, 1, 1, 0, 2, 2, 0};
        logic        b_sg [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
        logic [31:0] b_ad [10] = '{32'h40, 32'h40, 32'h41, 32'h40, 32'h42,
                                   32'h42, 32'h41, 32'h41, 32'h44, 32'h47};
        logic [31:0] b_wd [10] = '{32'h01020304, 0, 32'hAA, 0, 32'h8001,
                                   0, 0, 0, 32'hCAFEF00D, 0};
        logic [32:0] b_ex [10] = '{33'h0, 33'h001020304, 33'h0, 33'h00102AA04,
                                   33'h0, 33'h0FFFF8001, 33'h0000000AA,
                                   33'h100000000, 33'h0, 33'h0FFFFFFCA};
        int i; int r; int acc; logic pend;
        i = 0; r = 0; acc = 0;
        set_req(b_we[0], b_sz[0], b_sg[0], b_ad[0], b_wd[0]);
        bus.req_valid = 1'b1;
        pend = bus.req_ready;
        for (int c = 0; c < 100 && r < 10; c++) begin
            @(posedge clk); #1;
            if (pend) begin
                acc++;
                i++;
                if (i < 10)
                    set_req(b_we[i], b_sz[i], b_sg[i], b_ad[i], b_wd[i]);
                else
                    bus.req_valid = 1'b0;
            end
            if (bus.resp_valid) begin
                n_chk++;
                if ({bus.resp_err, bus.resp_rdata} !== b_ex[r]) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got err %b data %h want %h",
                             r, bus.resp_err, bus.resp_rdata, b_ex[r]);
                end
                r++;
            end
            pend = bus.req_ready && bus.req_valid;
        end
        bus.req_valid = 1'b0;
        n_chk++;
        if (r !== 10 || acc !== 10) begin
            n_fail++; $display("FAIL b2b_count: got %0d resps %0d accepts want 10 10", r, acc);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        pl_en = 1'b0; pl_idx = 5'd0; pl_data = 32'h0;
        bus.req_valid = 1'b0;
        set_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 32; k++) mem[k] = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_rmw();
        test_back_to_back();
        n_chk++;
        if (n_both !== 0) begin
            n_fail++; $display("FAIL rd_wr_overlap: got %0d cycles want 0", n_both);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

CPU-side initiator for the word-addressed data memory. It takes load/store requests from the datapath for byte, halfword or word accesses and drives the memory's read-enable, write-enable, address and write-data pins. Sub-word stores are done as read-modify-write, because the memory only writes whole words. Loads are returned sign- or zero-extended, and misaligned or out-of-range requests are rejected with an error flag without touching memory.

## Interface
- MEM_WORDS, default 32: number of 32-bit words in the attached memory. A request whose word index `addr[31:2]` is ≥ MEM_WORDS is out of range.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected; qualified by resp_valid.
- mem_read  out  1  read enable to memory.
- mem_write  out  1  write enable to memory; memory writes on posedge clk.
- mem_addr  out  32  word-aligned byte address, `{addr[31:2], 2'b00}`.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational read data, valid in the same cycle mem_read is high.

## Operation
- **States:** IDLE, READ, WRITE, RESP.
- **IDLE**
  - req_ready = 1 (forced 0 while rst is high).
  - On req_valid, latch we, size, signed, addr and wdata.
  - If the request is illegal, go to RESP with error set.
  - Otherwise: loads and sub-word stores go to READ; word stores go to WRITE.
- **Illegal request** is any of:
  - size = 11;
  - halfword with addr[0] = 1;
  - word with addr[1:0] ≠ 00;
  - word index ≥ MEM_WORDS.
- **READ**
  - mem_read = 1.
  - Load: capture the extended lane into resp_rdata, then go to RESP.
  - Sub-word store: merge the store lane into mem_rdata and register the result, then go to WRITE.
- **WRITE**
  - mem_write = 1.
  - mem_wdata = the merged word, or the latched wdata for a word store.
  - Next state: RESP.
- **RESP**
  - resp_valid = 1 for exactly one cycle; resp_err and resp_rdata are held for that cycle.
  - Next state: IDLE. No response backpressure.
- **Lanes (little-endian)**
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword lane = addr[1]: 0 is [15:0], 1 is [31:16].
  - Bytes of the word outside the target lane are preserved by the merge.
- **Extension:** a byte load extends bit 7 of the lane; a halfword load extends bit 15. Zero-extend when req_signed = 0.
- **Output decoding**
  - mem_read and mem_write are decoded from state and are never high together.
  - mem_addr is don't-care when both are low; drive it to 0.

## Timing
- Request accepted at edge N (req_valid & req_ready).
- **Latency from acceptance:**

  | Request | Sequence | resp_valid high in cycle |
  |---|---|---|
  | Load | READ in cycle N+1 | N+2 |
  | Word store | WRITE in N+1; memory updated at edge N+2 | N+2 |
  | Sub-word store | READ in N+1, WRITE in N+2; memory updated at edge N+3 | N+3 |
  | Error | no memory access | N+1 |

- req_ready is low from acceptance through RESP. The next request can be accepted the cycle after RESP.
- **Reset values:**
  - state = IDLE;
  - resp_valid, resp_err, mem_read, mem_write = 0;
  - resp_rdata, mem_addr, mem_wdata = 0;
  - req_ready = 0 while rst is high, 1 after release.
- **Reset mid-operation:** the operation is aborted immediately. mem_write drops asynchronously, so a store that has not completed its WRITE edge leaves memory unchanged, and no response is issued.
- req_* inputs are ignored outside IDLE; latched values are unaffected by later input changes.

## Test plan
- **Word store then load:** SW 0xDEADBEEF to 0x10, then LW 0x10.
  - The store produces one mem_write pulse at mem_addr 0x10 and resp_valid 2 cycles after acceptance.
  - The load returns resp_rdata 0xDEADBEEF 2 cycles after acceptance.
- **Byte store and byte loads:** preload word 0x11223344 at 0x10, then SB 0x80 to 0x13.
  - Sequence is mem_read then mem_write with mem_wdata 0x80223344; resp_valid 3 cycles after acceptance.
  - LB 0x13 returns 0xFFFFFF80; LBU 0x13 returns 0x00000080.
- **Halfword store and loads:** SH 0xABCD at 0x12 over 0x00001234.
  - The word becomes 0xABCD1234.
  - LH 0x12 returns 0xFFFFABCD; LHU 0x12 returns 0x0000ABCD; LHU 0x10 returns 0x00001234.
- **Error requests:** LW 0x06, SH 0x03, size 11 at 0x00, and LW 0x80 with MEM_WORDS = 32.
  - Each gives resp_valid with resp_err = 1 and resp_rdata = 0 one cycle after acceptance.
  - mem_read and mem_write never assert; memory contents are unchanged.
- **Reset during RMW:** assert rst during the READ cycle of an SB.
  - mem_write never asserts and no resp_valid is issued.
  - The target word is unchanged, and req_ready = 1 the cycle after rst release.
- **Back-to-back requests:** hold req_valid high for 10 requests.
  - Acceptance happens only when req_ready = 1.
  - Exactly one resp_valid per request, in order.
  - mem_read and mem_write are never high together.
